// File: rtl/event_writer.sv
// rtl/event_writer.sv - coincidence event builder feeding the event FIFO
//
// Groups rising hit edges seen within a WINDOW-cycle coincidence window into
// one event and writes {hit_mask[15:0], timestamp[47:0]} into the event FIFO.
// After each event, new hits are ignored for DEADTIME cycles.
//
// Ports:
//   clk          system clock
//   areset       asynchronous reset, active-high
//   enable_i     arms event capture (level)
//   hit_i        channel discriminator levels, synchronous to clk
//   full_i       event FIFO full
//   din_o        FIFO write data, holds the last written word
//   wr_en_o      FIFO write strobe, one cycle per accepted event
//   busy_o       high whenever the FSM is not idle
//   event_cnt_o  events written (wraps)
//   drop_cnt_o   events dropped on a full FIFO (saturating)
//
// Build option: EVENT_WRITER_DROP_CNT_EN enables the drop counter; without it
// drop_cnt_o is tied to zero and dropped events are simply not written.

module event_writer #(
    parameter int N_CH     = 16,
    parameter int WINDOW   = 8,
    parameter int DEADTIME = 16
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            enable_i,
    input  logic [N_CH-1:0] hit_i,
    input  logic            full_i,
    output logic [63:0]     din_o,
    output logic            wr_en_o,
    output logic            busy_o,
    output logic [31:0]     event_cnt_o,
    output logic [15:0]     drop_cnt_o
);

    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DEAD    = 2'd3
    } state_t;

    state_t            state;
    logic [47:0]       ts_cnt;
    logic [47:0]       ts_cap;
    logic [N_CH-1:0]   hit_q;
    logic [15:0]       mask;
    logic [WIN_W-1:0]  win;
    logic [DEAD_W-1:0] dead;
    logic [15:0]       rise;

    // Rising edges only, so a channel held high contributes a single hit.
    assign rise = 16'(hit_i & ~hit_q);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            ts_cnt      <= 48'd0;
            ts_cap      <= 48'd0;
            hit_q       <= '0;
            mask        <= 16'd0;
            win         <= '0;
            dead        <= '0;
            din_o       <= 64'd0;
            wr_en_o     <= 1'b0;
            busy_o      <= 1'b0;
            event_cnt_o <= 32'd0;
`ifdef EVENT_WRITER_DROP_CNT_EN
            drop_cnt_o  <= 16'd0;
`endif
        end else begin
            ts_cnt  <= ts_cnt + 48'd1;
            hit_q   <= hit_i;
            wr_en_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable_i && (rise != 16'd0)) begin
                        ts_cap <= ts_cnt;
                        mask   <= rise;
                        win    <= WIN_W'(WINDOW - 1);
                        state  <= COLLECT;
                        busy_o <= 1'b1;
                    end
                end

                COLLECT: begin
                    // The final window cycle still merges its rises.
                    mask <= mask | rise;
                    if (win == '0) begin
                        state <= WRITE;
                    end else begin
                        win <= win - 1'b1;
                    end
                end

                WRITE: begin
                    if (!full_i) begin
                        din_o       <= {mask, ts_cap};
                        wr_en_o     <= 1'b1;
                        event_cnt_o <= event_cnt_o + 32'd1;
                    end else begin
`ifdef EVENT_WRITER_DROP_CNT_EN
                        if (drop_cnt_o != 16'hFFFF) begin
                            drop_cnt_o <= drop_cnt_o + 16'd1;
                        end
`endif
                    end
                    if (DEADTIME == 0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        dead  <= DEAD_W'(DEADTIME - 1);
                        state <= DEAD;
                    end
                end

                DEAD: begin
                    // Rises are dropped here, but hit_q keeps tracking so a
                    // level that stays high will not retrigger on return to IDLE.
                    if (dead == '0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        dead <= dead - 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`ifndef EVENT_WRITER_DROP_CNT_EN
    assign drop_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_event_writer.sv
// tb/tb_event_writer.sv - self-checking bench for event_writer

module tb_event_writer;

    localparam int N_CH     = 16;
    localparam int WINDOW   = 8;
    localparam int DEADTIME = 16;

    logic            clk = 1'b0;
    logic            areset = 1'b1;
    logic            enable_i = 1'b0;
    logic [N_CH-1:0] hit_i = '0;
    logic            full_i = 1'b0;
    logic [63:0]     din_o;
    logic            wr_en_o;
    logic            busy_o;
    logic [31:0]     event_cnt_o;
    logic [15:0]     drop_cnt_o;

    event_writer #(.N_CH(N_CH), .WINDOW(WINDOW), .DEADTIME(DEADTIME)) dut (
        .clk         (clk),
        .areset      (areset),
        .enable_i    (enable_i),
        .hit_i       (hit_i),
        .full_i      (full_i),
        .din_o       (din_o),
        .wr_en_o     (wr_en_o),
        .busy_o      (busy_o),
        .event_cnt_o (event_cnt_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks events by cycle number rather than FSM state.
    longint          m_cyc;
    longint          m_start;
    longint          m_idle_from;
    logic [47:0]     m_ts;
    logic [47:0]     m_tscap;
    logic [15:0]     m_mask;
    logic            m_open;
    logic [N_CH-1:0] m_prev;
    logic            exp_wr;
    logic [63:0]     exp_din;
    logic [31:0]     exp_evt;
    logic [15:0]     exp_drop;
    logic            exp_busy;
    logic            ts_req = 1'b0;
    logic [47:0]     ts_req_val = 48'd0;

    always @(posedge clk or posedge areset) begin
        logic [15:0] r;
        if (areset) begin
            m_cyc = 0; m_start = 0; m_idle_from = 0;
            m_ts = 48'd0; m_tscap = 48'd0; m_mask = 16'd0; m_open = 1'b0;
            m_prev = '0; exp_wr = 1'b0; exp_din = 64'd0; exp_evt = 32'd0;
            exp_drop = 16'd0; exp_busy = 1'b0;
        end else begin
            if (ts_req) m_ts = ts_req_val;
            r = 16'(hit_i & ~m_prev);
            m_prev = hit_i;
            exp_wr = 1'b0;
            if (m_open) begin
                if (m_cyc <= m_start + WINDOW) begin
                    m_mask = m_mask | r;
                end else begin
                    if (!full_i) begin
                        exp_wr  = 1'b1;
                        exp_din = {m_mask, m_tscap};
                        exp_evt = exp_evt + 32'd1;
                    end else begin
`ifdef EVENT_WRITER_DROP_CNT_EN
                        if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
`endif
                    end
                    m_open = 1'b0;
                    m_idle_from = m_cyc + 1 + DEADTIME;
                end
            end else if (m_cyc >= m_idle_from && enable_i && r != 16'd0) begin
                m_open  = 1'b1;
                m_start = m_cyc;
                m_tscap = m_ts;
                m_mask  = r;
            end
            exp_busy = m_open || (m_cyc + 1 < m_idle_from);
            m_ts  = m_ts + 48'd1;
            m_cyc = m_cyc + 1;
        end
    end

    logic   chk_en = 1'b0;
    int     n_wr_seen = 0;

    always @(negedge clk) begin
        if (!areset && chk_en) begin
            check("wr_en", 64'(wr_en_o), 64'(exp_wr));
            check("busy", 64'(busy_o), 64'(exp_busy));
            check("din", din_o, exp_din);
            check("event_cnt", 64'(event_cnt_o), 64'(exp_evt));
            check("drop_cnt", 64'(drop_cnt_o), 64'(exp_drop));
            if (wr_en_o) n_wr_seen++;
        end
    end

    task automatic do_reset();
        hit_i = '0; enable_i = 1'b0; full_i = 1'b0;
        areset = 1'b1;
        repeat (3) @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int          wr0;
    logic [31:0] evt0;
    logic [15:0] drop0;
    logic [15:0] exp_drop_dir;

    initial begin
        @(negedge clk);
        #1;
        check("rst_wr_en", 64'(wr_en_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_din", din_o, 64'd0);
        check("rst_event_cnt", 64'(event_cnt_o), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);

        // Single hit sampled at the edge where ts_cnt == 100.
        do_reset();
        chk_en = 1'b1;
        enable_i = 1'b1;
        idle(100);
        hit_i[3] = 1'b1;
        wr0 = n_wr_seen;
        idle(30);
        check("t1_nwr", 64'(n_wr_seen - wr0), 64'd1);
        check("t1_din", din_o, 64'h0008_0000_0000_0064);
        check("t1_cnt", 64'(event_cnt_o), 64'd1);
        hit_i = '0;
        idle(30);

        // Rise on the last collect cycle is merged.
        wr0 = n_wr_seen;
        hit_i[0] = 1'b1;
        idle(8);
        hit_i[15] = 1'b1;
        idle(30);
        check("t2_nwr", 64'(n_wr_seen - wr0), 64'd1);
        check("t2_mask", 64'(din_o[63:48]), 64'h8001);
        hit_i = '0;
        idle(30);

        // One cycle later it lands in WRITE and is lost.
        wr0 = n_wr_seen;
        hit_i[0] = 1'b1;
        idle(9);
        hit_i[15] = 1'b1;
        idle(40);
        check("t3_nwr", 64'(n_wr_seen - wr0), 64'd1);
        check("t3_mask", 64'(din_o[63:48]), 64'h0001);
        hit_i = '0;
        idle(30);

        // Full FIFO during WRITE.
        wr0 = n_wr_seen; evt0 = event_cnt_o; drop0 = drop_cnt_o;
        full_i = 1'b1;
        hit_i[5] = 1'b1;
        idle(1);
        hit_i[5] = 1'b0;
        idle(30);
        full_i = 1'b0;
`ifdef EVENT_WRITER_DROP_CNT_EN
        exp_drop_dir = drop0 + 16'd1;
`else
        exp_drop_dir = 16'd0;
`endif
        check("t4_nwr", 64'(n_wr_seen - wr0), 64'd0);
        check("t4_cnt", 64'(event_cnt_o), 64'(evt0));
        check("t4_drop", 64'(drop_cnt_o), 64'(exp_drop_dir));

        // Held-high hit produces one event.
        wr0 = n_wr_seen;
        hit_i[2] = 1'b1;
        idle(100);
        hit_i = '0;
        idle(30);
        check("t5_held", 64'(n_wr_seen - wr0), 64'd1);

        // Disabled capture ignores pulses.
        enable_i = 1'b0;
        wr0 = n_wr_seen;
        for (int i = 0; i < 10; i++) begin
            hit_i = N_CH'($urandom);
            idle(2);
            hit_i = '0;
            idle(3);
        end
        idle(30);
        check("t5_disabled", 64'(n_wr_seen - wr0), 64'd0);
        enable_i = 1'b1;
        idle(30);

        // Timestamp wrap within an event keeps the pre-wrap capture.
        force dut.ts_cnt = 48'hFFFF_FFFF_FFFE;
        release dut.ts_cnt;
        ts_req_val = 48'hFFFF_FFFF_FFFE;
        ts_req = 1'b1;
        hit_i[7] = 1'b1;
        wr0 = n_wr_seen;
        idle(1);
        ts_req = 1'b0;
        idle(30);
        check("t6_nwr", 64'(n_wr_seen - wr0), 64'd1);
        check("t6_din", din_o, 64'h0080_FFFF_FFFF_FFFE);
        hit_i = '0;
        idle(30);

        // Reset during COLLECT discards the event.
        hit_i[1] = 1'b1;
        idle(3);
        #2;
        areset = 1'b1;
        #1;
        check("t7_wr_en", 64'(wr_en_o), 64'd0);
        check("t7_busy", 64'(busy_o), 64'd0);
        check("t7_din", din_o, 64'd0);
        check("t7_cnt", 64'(event_cnt_o), 64'd0);
        check("t7_drop", 64'(drop_cnt_o), 64'd0);
        hit_i = '0;
        idle(2);
        wr0 = n_wr_seen;
        areset = 1'b0;
        idle(30);
        check("t7_nwr", 64'(n_wr_seen - wr0), 64'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            enable_i = ($urandom_range(0, 7) != 0);
            full_i   = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 40) == 0) hit_i[c] = ~hit_i[c];
            end
            idle(1);
        end
        hit_i = '0;
        full_i = 1'b0;
        idle(40);
        check("rand_some_writes", 64'(n_wr_seen > 20), 64'd1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
